// File: rtl/rt_sample_feed.sv
// Paces FIFO words out as interleaved multi-channel sample frames on a programmable tick.
// It prefetches one word, slices it into frames LSB-first, and counts underruns when a tick finds no data.
module rt_sample_feed #(
  parameter int WORD_W   = 16,
  parameter int SAMPLE_W = 2,
  parameter int NUM_CH   = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         flush,
  input  logic [15:0]                  rate_div,
  input  logic                         clear_status,
  input  logic [WORD_W-1:0]            fifo_rd_data,
  input  logic                         fifo_rd_empty,
  output logic                         fifo_rd_req,
  output logic [NUM_CH*SAMPLE_W-1:0]   sample_data,
  output logic                         sample_valid,
  output logic                         underrun,
  output logic [15:0]                  underrun_count
);

  localparam int FW    = NUM_CH * SAMPLE_W;
  localparam int F     = WORD_W / FW;
  localparam int IDX_W = (F > 1) ? $clog2(F) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(F - 1);

  // state   | meaning
  // S_EMPTY | no word buffered; read issued when FIFO has data
  // S_FETCH | read issued, FIFO data arrives this cycle
  // S_READY | word buffered, r_idx selects next frame
  typedef enum logic [1:0] {S_EMPTY, S_FETCH, S_READY} state_t;

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_cnt;
  logic [WORD_W-1:0]   r_word;
  logic [WORD_W-1:0]   w_word_shift;
  logic [FW-1:0]       w_frame;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic                r_run;
  logic                w_tick, w_consume, w_underrun, w_last, w_load, w_rd_req;

  // >= rather than == so a rate_div lowered below the running count still wraps
  assign w_tick     = enable && (r_cnt >= rate_div);
  assign w_consume  = w_tick && !flush && (r_state == S_READY);
  assign w_underrun = w_tick && !flush && (r_state != S_READY);
  assign w_last     = (r_idx == LAST_IDX);

  assign w_word_shift = r_word >> (32'(r_idx) * FW);
  assign w_frame      = w_word_shift[FW-1:0];
  assign fifo_rd_req  = w_rd_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 16'd0;
    end else if (!enable || w_tick) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_EMPTY;
      r_idx   <= '0;
      r_word  <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_run   <= 1'b1;
      if (w_load) r_word <= fifo_rd_data;
    end
  end

  // r_run keeps reads off until the first clock edge after reset release
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rd_req    = 1'b0;
    w_load      = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (!fifo_rd_empty && r_run) begin
            w_rd_req    = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
        S_FETCH: begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_READY;
        end
        S_READY: begin
          if (w_consume) begin
            if (!w_last) begin
              w_idx_nxt = r_idx + 1'b1;
            end else begin
              w_idx_nxt = '0;
              if (!fifo_rd_empty) begin
                w_rd_req    = 1'b1;
                w_state_nxt = S_FETCH;
              end else begin
                w_state_nxt = S_EMPTY;
              end
            end
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= w_consume;
      if (w_consume) sample_data <= w_frame;
    end
  end

  // a clear coinciding with an underrun leaves exactly that one underrun recorded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun       <= 1'b0;
      underrun_count <= 16'd0;
    end else if (clear_status) begin
      underrun       <= w_underrun;
      underrun_count <= w_underrun ? 16'd1 : 16'd0;
    end else if (w_underrun) begin
      underrun <= 1'b1;
      if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_rt_sample_feed.sv
// Directed bench for rt_sample_feed: default geometry plus F=16 and F=1 instances,
// each fed by a simple FIFO model with one-cycle read latency.
module tb_rt_sample_feed;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, enable, flush, clear_status;
  logic [15:0] rate_div;

  logic [15:0] rd0 = '0, rd1 = '0, rd2 = '0;
  logic        em0, em1, em2, rq0, rq1, rq2;
  logic        sv0, sv1, sv2, ur0, ur1, ur2;
  logic [3:0]  sd0;
  logic [0:0]  sd1;
  logic [15:0] sd2;
  logic [15:0] uc0, uc1, uc2;

  rt_sample_feed dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush), .rate_div(rate_div),
    .clear_status(clear_status), .fifo_rd_data(rd0), .fifo_rd_empty(em0), .fifo_rd_req(rq0),
    .sample_data(sd0), .sample_valid(sv0), .underrun(ur0), .underrun_count(uc0));

  rt_sample_feed #(.WORD_W(16), .SAMPLE_W(1), .NUM_CH(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush), .rate_div(rate_div),
    .clear_status(clear_status), .fifo_rd_data(rd1), .fifo_rd_empty(em1), .fifo_rd_req(rq1),
    .sample_data(sd1), .sample_valid(sv1), .underrun(ur1), .underrun_count(uc1));

  rt_sample_feed #(.WORD_W(16), .SAMPLE_W(4), .NUM_CH(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush), .rate_div(rate_div),
    .clear_status(clear_status), .fifo_rd_data(rd2), .fifo_rd_empty(em2), .fifo_rd_req(rq2),
    .sample_data(sd2), .sample_valid(sv2), .underrun(ur2), .underrun_count(uc2));

  // FIFO models: pointers only ever grow, the initial block writes, the always block reads
  logic [15:0] mem0 [64], mem1 [64], mem2 [64];
  int wp0 = 0, wp1 = 0, wp2 = 0, rp0 = 0, rp1 = 0, rp2 = 0;
  assign em0 = (wp0 == rp0);
  assign em1 = (wp1 == rp1);
  assign em2 = (wp2 == rp2);

  always @(posedge clk) if (rq0) begin rd0 <= mem0[rp0 % 64]; rp0 <= rp0 + 1; end
  always @(posedge clk) if (rq1) begin rd1 <= mem1[rp1 % 64]; rp1 <= rp1 + 1; end
  always @(posedge clk) if (rq2) begin rd2 <= mem2[rp2 % 64]; rp2 <= rp2 + 1; end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // frame recorders: value, cycle and underrun flag at every sample_valid
  logic [15:0] fr0 [256], fr1 [256], fr2 [256];
  int          fc0 [256];
  logic        fu0 [256], fu1 [256], fu2 [256];
  int n0 = 0, n1 = 0, n2 = 0, nreq0 = 0;
  int viol0 = 0, viol1 = 0, viol2 = 0;
  logic pr0 = 1'b0, pr1 = 1'b0, pr2 = 1'b0;

  always @(negedge clk) begin
    if (sv0 && n0 < 256) begin fr0[n0] <= 16'(sd0); fc0[n0] <= cyc; fu0[n0] <= ur0; n0 <= n0 + 1; end
    if (rq0) nreq0 <= nreq0 + 1;
    if (rq0 && (em0 || pr0)) viol0 <= viol0 + 1;
    pr0 <= rq0;
  end
  always @(negedge clk) begin
    if (sv1 && n1 < 256) begin fr1[n1] <= 16'(sd1); fu1[n1] <= ur1; n1 <= n1 + 1; end
    if (rq1 && (em1 || pr1)) viol1 <= viol1 + 1;
    pr1 <= rq1;
  end
  always @(negedge clk) begin
    if (sv2 && n2 < 256) begin fr2[n2] <= sd2; fu2[n2] <= ur2; n2 <= n2 + 1; end
    if (rq2 && (em2 || pr2)) viol2 <= viol2 + 1;
    pr2 <= rq2;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push0(input logic [15:0] w); mem0[wp0 % 64] = w; wp0++; endtask
  task automatic push1(input logic [15:0] w); mem1[wp1 % 64] = w; wp1++; endtask
  task automatic push2(input logic [15:0] w); mem2[wp2 % 64] = w; wp2++; endtask

  task automatic wait_n0(input int base, input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (n0 >= base + n) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic flush_clear();
    flush = 1'b1; clear_status = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; clear_status = 1'b0;
  endtask

  typedef struct {
    logic [15:0] rate;
    logic [15:0] w0;
    logic [15:0] w1;
    int          nw;
    logic [31:0] exp;   // expected frames, frame 0 in bits [3:0]
  } vec_t;

  vec_t vecs [4];

  initial begin
    bit ok;
    int base, rb, m;
    logic [31:0] e;
    logic [15:0] e1;

    vecs[0] = '{16'd3, 16'hE4E4, 16'h0000, 1, 32'h0000E4E4};
    vecs[1] = '{16'd1, 16'h1234, 16'hABCD, 2, 32'hABCD1234};
    vecs[2] = '{16'd2, 16'h0F5A, 16'hC3C3, 2, 32'hC3C30F5A};
    vecs[3] = '{16'd5, 16'hFFFF, 16'h0001, 2, 32'h0001FFFF};

    reset_n = 1'b0; enable = 1'b0; flush = 1'b0; clear_status = 1'b0; rate_div = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    push0(16'h5A5A);
    #1;
    chk("rst_sample_data", 32'(sd0), 32'h0);
    chk("rst_sample_valid", 32'(sv0), 32'h0);
    chk("rst_underrun", 32'(ur0), 32'h0);
    chk("rst_count", 32'(uc0), 32'h0);
    chk("rst_rd_req_held", 32'(rq0), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("rd_req_before_first_edge", 32'(rq0), 32'h0);
    @(posedge clk); #1;
    chk("rd_req_after_first_edge", 32'(rq0), 32'h1);
    repeat (2) @(posedge clk); #1;
    flush_clear();

    // empty FIFO, rate_div=0, ten enabled edges
    base = n0; rb = nreq0;
    rate_div = 16'd0; enable = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("empty_no_valid", 32'(n0 - base), 32'd0);
    chk("empty_no_rd_req", 32'(nreq0 - rb), 32'd0);
    chk("empty_underrun", 32'(ur0), 32'h1);
    chk("empty_count10", 32'(uc0), 32'd10);
    clear_status = 1'b1;
    @(posedge clk); #1;
    chk("clear_with_underrun_flag", 32'(ur0), 32'h1);
    chk("clear_with_underrun_count", 32'(uc0), 32'd1);
    enable = 1'b0;
    @(posedge clk); #1;
    clear_status = 1'b0;
    chk("clear_flag", 32'(ur0), 32'h0);
    chk("clear_count", 32'(uc0), 32'd0);

    for (int v = 0; v < 4; v++) begin
      rb = nreq0;
      rate_div = vecs[v].rate;
      push0(vecs[v].w0);
      if (vecs[v].nw == 2) push0(vecs[v].w1);
      repeat (4) @(posedge clk); #1;
      base = n0;
      enable = 1'b1;
      m = vecs[v].nw * 4;
      wait_n0(base, m, ok);
      enable = 1'b0;
      chk($sformatf("v%0d_frames_seen", v), 32'(ok), 32'h1);
      e = vecs[v].exp;
      for (int i = 0; i < m; i++) begin
        chk($sformatf("v%0d_frame%0d", v, i), 32'(fr0[base + i]), 32'(e[i*4 +: 4]));
        if (i > 0)
          chk($sformatf("v%0d_period%0d", v, i), 32'(fc0[base + i] - fc0[base + i - 1]),
              32'(vecs[v].rate) + 32'd1);
      end
      chk($sformatf("v%0d_no_underrun", v), 32'(fu0[base + m - 1]), 32'h0);
      chk($sformatf("v%0d_rd_reqs", v), 32'(nreq0 - rb), 32'(vecs[v].nw));
      flush_clear();
      chk($sformatf("v%0d_status_cleared", v), {15'd0, ur0, uc0}, 32'h0);
    end

    // flush during FETCH discards the returning word
    rb = nreq0;
    push0(16'hDEAD);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_one_read", 32'(nreq0 - rb), 32'd1);
    push0(16'h7130);
    repeat (4) @(posedge clk); #1;
    base = n0; rate_div = 16'd1; enable = 1'b1;
    wait_n0(base, 4, ok);
    enable = 1'b0;
    chk("flush_frames_seen", 32'(ok), 32'h1);
    e1 = 16'h7130;
    for (int i = 0; i < 4; i++)
      chk($sformatf("flush_frame%0d", i), 32'(fr0[base + i]), 32'(e1[i*4 +: 4]));
    chk("flush_rd_reqs", 32'(nreq0 - rb), 32'd2);
    flush_clear();

    // parameter sweep: F=16 and F=1
    push1(16'hA5C3);
    push2(16'h1234); push2(16'h5678); push2(16'h9ABC);
    repeat (4) @(posedge clk); #1;
    base = n1; rb = n2;
    rate_div = 16'd1; enable = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (n1 >= base + 16 && n2 >= rb + 3) begin ok = 1'b1; break; end
    end
    #1;
    enable = 1'b0;
    chk("sweep_frames_seen", 32'(ok), 32'h1);
    e1 = 16'hA5C3;
    for (int i = 0; i < 16; i++)
      chk($sformatf("f16_bit%0d", i), 32'(fr1[base + i]), 32'(e1[i]));
    chk("f16_no_underrun", 32'(fu1[base + 15]), 32'h0);
    chk("f1_frame0", 32'(fr2[rb]), 32'h1234);
    chk("f1_frame1", 32'(fr2[rb + 1]), 32'h5678);
    chk("f1_frame2", 32'(fr2[rb + 2]), 32'h9ABC);
    chk("f1_no_underrun", 32'(fu2[rb + 2]), 32'h0);
    flush_clear();

    // saturation of the underrun counter
    rate_div = 16'd0; enable = 1'b1;
    repeat (65534) @(posedge clk); #1;
    chk("count_fffe", 32'(uc0), 32'hFFFE);
    repeat (3) @(posedge clk); #1;
    chk("count_saturated", 32'(uc0), 32'hFFFF);
    chk("sat_underrun", 32'(ur0), 32'h1);
    enable = 1'b0;

    // reset while a read is in flight
    push0(16'h9999);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midfetch_rst_sample_data", 32'(sd0), 32'h0);
    chk("midfetch_rst_valid", 32'(sv0), 32'h0);
    chk("midfetch_rst_underrun", 32'(ur0), 32'h0);
    chk("midfetch_rst_count", 32'(uc0), 32'h0);
    chk("midfetch_rst_rd_req", 32'(rq0), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    base = n0;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    chk("midfetch_data_discarded", 32'(ur0), 32'h1);
    chk("midfetch_no_valid", 32'(n0 - base), 32'd0);

    chk("rd_req_rule_f4", 32'(viol0), 32'd0);
    chk("rd_req_rule_f16", 32'(viol1), 32'd0);
    chk("rd_req_rule_f1", 32'(viol2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rt_sample_feed.md
RT_SAMPLE_FEED -- requirements
Module: rt_sample_feed

Interface
REQ-001 Parameters, one per line:
- WORD_W, default 16, RX FIFO word width.
- SAMPLE_W, default 2, bits per GPS sample.
- NUM_CH, default 2, interleaved sample channels.
REQ-002 Parameter legality: WORD_W divisible by SAMPLE_W*NUM_CH; F = WORD_W/(SAMPLE_W*NUM_CH) frames per word (F>=1).
REQ-003 Ports, one per line:
- clk, in, 1, single clock for all logic.
- reset_n, in, 1, asynchronous active-low reset.
- enable, in, 1, run sample timing.
- flush, in, 1, discard buffered/in-flight data.
- rate_div, in, 16, sample period minus one, in clk cycles.
- clear_status, in, 1, clear underrun flag and counter.
- fifo_rd_data, in, WORD_W, FIFO read data, valid one cycle after fifo_rd_req.
- fifo_rd_empty, in, 1, FIFO empty.
- fifo_rd_req, out, 1, FIFO read request.
- sample_data, out, NUM_CH*SAMPLE_W, current frame; channel c at bits [c*SAMPLE_W +: SAMPLE_W].
- sample_valid, out, 1, one-cycle frame strobe.
- underrun, out, 1, sticky underrun flag.
- underrun_count, out, 16, saturating underrun counter.

Function
REQ-004 Tick generator: 16-bit counter; while enable=1, counts 0..rate_div, tick asserted the cycle it equals rate_div, then wraps to 0; rate_div=0 -> tick every cycle.
REQ-005 enable=0: counter held at 0, no ticks; buffered word and frame index retained.
REQ-006 States: EMPTY (no word), FETCH (read issued, awaiting data), READY (word buffered, frame index idx in 0..F-1).
REQ-007 EMPTY: fifo_rd_req=1 iff fifo_rd_empty=0 and flush=0; when asserted -> FETCH.
REQ-008 FETCH: fifo_rd_data captured into word buffer the following cycle; idx=0; -> READY. fifo_rd_req=0 in FETCH.
REQ-009 Frame idx = word bits [idx*NUM_CH*SAMPLE_W +: NUM_CH*SAMPLE_W] (LSB first); sample k of word maps to channel k mod NUM_CH.
REQ-010 Tick in READY:
- sample_data <= frame idx; sample_valid=1 next cycle.
- If idx<F-1: idx++.
- If idx=F-1: buffer released. fifo_rd_req asserted this same cycle if fifo_rd_empty=0 (-> FETCH), else -> EMPTY.
REQ-011 Underrun: tick in EMPTY or FETCH.
- sample_valid=0; sample_data holds its last value.
- underrun<=1; underrun_count increments, saturating at 16'hFFFF.
REQ-012 fifo_rd_req never asserted while fifo_rd_empty=1; at most one outstanding read.
REQ-013 flush=1:
- Next state EMPTY; idx=0.
- Data returning from a read issued the previous cycle is discarded.
- No tick consumes data that cycle (no sample_valid, no underrun).
- Tick counter is not reset by flush.
REQ-014 clear_status=1 clears underrun and underrun_count next cycle; if an underrun occurs the same cycle, the result is underrun=1, count=1.
REQ-015 Simultaneous flush and clear_status: both take effect.
REQ-016 sample_valid is a registered, single-cycle pulse; latency from tick to sample_valid = 1 cycle.

Reset
REQ-017 reset_n=0 asynchronously forces:
- state EMPTY, idx=0, tick counter 0, word buffer 0.
- fifo_rd_req=0, sample_valid=0, sample_data=0, underrun=0, underrun_count=0.
REQ-018 Reset asserted mid-FETCH: returning FIFO data is discarded. After release, the first read is issued no earlier than the first clk edge with reset_n=1.

Verification
REQ-019 Defaults (F=4), rate_div=3, FIFO holds 16'hE4E4, enable=1 -> sample_valid every 4 cycles with sample_data 2'b00|2'b01<<2=4'h4, then 4'hE, 4'h4, 4'hE; exactly one fifo_rd_req.
REQ-020 Empty FIFO, enable=1, rate_div=0 for 10 cycles -> no sample_valid, fifo_rd_req=0, underrun=1, underrun_count=10; then clear_status -> 0.
REQ-021 Two words 16'h1234, 16'hABCD, rate_div=1 -> 8 frames in order 4'h4,4'h3,4'h2,4'h1,4'hD,4'hC,4'hB,4'hA; no underrun (refetch overlaps last frame).
REQ-022 flush asserted the cycle after fifo_rd_req -> fetched word never appears on sample_data; next word read appears as frame 0.
REQ-023 underrun_count preloaded to 16'hFFFE by forcing 3 underruns -> saturates at 16'hFFFF; reset_n low mid-FETCH -> all outputs 0 immediately.
REQ-024 Parameter sweep SAMPLE_W=1, NUM_CH=1 (F=16) and SAMPLE_W=4, NUM_CH=4 (F=1) -> frame ordering per REQ-009; F=1 case with rate_div=1 shows no underrun.
